// File: rtl/alu_operand_pkg.sv
// Shared definitions for the ALU operand selector.
// Holds the legacy select codes, default geometry and a slice helper used
// to pull one channel's select code out of a packed select bus.
package alu_operand_pkg;

  // Legacy select codes; 6 and 7 are spare src_bus slots with default geometry.
  localparam int unsigned SEL_ZERO = 0;
  localparam int unsigned SEL_IR   = 1;
  localparam int unsigned SEL_IDX  = 2;
  localparam int unsigned SEL_IDY  = 3;
  localparam int unsigned SEL_R1   = 4;
  localparam int unsigned SEL_R5   = 5;

  localparam int unsigned DEFAULT_DATA_W  = 16;
  localparam int unsigned DEFAULT_SEL_W   = 3;
  localparam int unsigned DEFAULT_NUM_SRC = 8;
  localparam int unsigned DEFAULT_NUM_CH  = 2;

  // Returns field 'ch' of width 'w' from a packed bus of up to 32 bits.
  function automatic logic [31:0] chan_slice(input logic [31:0] bus,
                                             input int unsigned ch,
                                             input int unsigned w);
    logic [31:0] mask;
    mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return (bus >> (ch * w)) & mask;
  endfunction

endpackage

// File: rtl/alu_operand_skid.sv
// Generic 2-entry valid/ready FIFO buffer.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   i_valid / o_ready  upstream handshake; o_ready depends on state only
//   i_data             entry written on an upstream transfer
//   o_valid / i_ready  downstream handshake
//   o_data             head entry, held stable while stalled
module alu_operand_skid #(
  parameter int unsigned WIDTH = 34
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data
);

  logic [1:0]       r_count;
  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_tail;
  logic             w_push;
  logic             w_pop;

  assign o_ready = (r_count != 2'd2);
  assign o_valid = (r_count != 2'd0);
  assign o_data  = r_head;
  assign w_push  = i_valid && o_ready;
  assign w_pop   = o_valid && i_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= 2'd0;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      case (r_count)
        2'd0: begin
          if (w_push) begin
            r_head  <= i_data;
            r_count <= 2'd1;
          end
        end
        2'd1: begin
          // Push with pop: the new entry replaces the departing head directly.
          if (w_push && w_pop) begin
            r_head <= i_data;
          end else if (w_push) begin
            r_tail  <= i_data;
            r_count <= 2'd2;
          end else if (w_pop) begin
            r_count <= 2'd0;
          end
        end
        2'd2: begin
          if (w_pop) begin
            r_head  <= r_tail;
            r_count <= 2'd1;
          end
        end
        default: r_count <= 2'd0;
      endcase
    end
  end

endmodule

// File: rtl/alu_operand_sel.sv
// ALU operand selector: picks NUM_CH operands per request from a shared bank
// of source registers, forwards a same-cycle write-back, flags illegal codes,
// and buffers the result in a 2-entry valid/ready FIFO.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   i_src_bus                  sources for codes 1..NUM_SRC-1, code k at (k-1)*DATA_W
//   i_in_valid / o_in_ready    request handshake
//   i_in_sel                   per-channel select code, channel c at c*SEL_W
//   i_wb_en/i_wb_sel/i_wb_data write-back forwarded into the accepted request
//   o_out_valid / i_out_ready  result handshake
//   o_out_data / o_out_err     head entry operands and illegal-code flags
//   o_err_sticky / i_err_clr   sticky illegal-code flag and its clear
// The select bus is extracted through a 32-bit helper, so NUM_CH*SEL_W <= 32.
module alu_operand_sel
  import alu_operand_pkg::*;
#(
  parameter int unsigned DATA_W  = DEFAULT_DATA_W,
  parameter int unsigned NUM_SRC = DEFAULT_NUM_SRC,
  parameter int unsigned SEL_W   = DEFAULT_SEL_W,
  parameter int unsigned NUM_CH  = DEFAULT_NUM_CH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [(NUM_SRC-1)*DATA_W-1:0] i_src_bus,
  input  logic                        i_in_valid,
  output logic                        o_in_ready,
  input  logic [NUM_CH*SEL_W-1:0]     i_in_sel,
  input  logic                        i_wb_en,
  input  logic [SEL_W-1:0]            i_wb_sel,
  input  logic [DATA_W-1:0]           i_wb_data,
  output logic                        o_out_valid,
  input  logic                        i_out_ready,
  output logic [NUM_CH*DATA_W-1:0]    o_out_data,
  output logic [NUM_CH-1:0]           o_out_err,
  output logic                        o_err_sticky,
  input  logic                        i_err_clr
);

  localparam int unsigned ENTRY_W = NUM_CH * (DATA_W + 1);

  logic [NUM_CH*DATA_W-1:0] w_cap_data;
  logic [NUM_CH-1:0]        w_cap_err;
  logic [ENTRY_W-1:0]       w_head;
  logic                     w_accept;
  logic                     r_err_sticky;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [SEL_W-1:0]  w_code;
    logic [DATA_W-1:0] w_val;
    logic              w_bad;

    assign w_code = SEL_W'(chan_slice(32'(i_in_sel), c, SEL_W));

    always_comb begin
      w_val = '0;
      w_bad = 1'b0;
      if (int'(w_code) == SEL_ZERO) begin
        w_val = '0;
      end else if (int'(w_code) < NUM_SRC) begin
        // Code 0 never reaches here, so a write-back to code 0 never forwards.
        if (i_wb_en && (i_wb_sel == w_code)) begin
          w_val = i_wb_data;
        end else begin
          w_val = i_src_bus[(int'(w_code) - 1) * DATA_W +: DATA_W];
        end
      end else begin
        w_bad = 1'b1;
      end
    end

    assign w_cap_data[c*DATA_W +: DATA_W] = w_val;
    assign w_cap_err[c]                   = w_bad;
  end

  assign w_accept = i_in_valid && o_in_ready;

  alu_operand_skid #(
    .WIDTH (ENTRY_W)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (i_in_valid),
    .o_ready (o_in_ready),
    .i_data  ({w_cap_err, w_cap_data}),
    .o_valid (o_out_valid),
    .i_ready (i_out_ready),
    .o_data  (w_head)
  );

  assign o_out_data = w_head[NUM_CH*DATA_W-1:0];
  assign o_out_err  = w_head[ENTRY_W-1 -: NUM_CH];

  // A new error in the same cycle as a clear takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_sticky <= 1'b0;
    end else if (w_accept && (|w_cap_err)) begin
      r_err_sticky <= 1'b1;
    end else if (i_err_clr) begin
      r_err_sticky <= 1'b0;
    end
  end

  assign o_err_sticky = r_err_sticky;

endmodule
